// File: rtl/dbus_rr_arbiter_if.sv
// dbus_rr_arbiter_if: N-master request/ready bus plus the single slave port, as seen by the arbiter
interface dbus_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MASK_WIDTH  = 4
);
  logic [NUM_MASTERS-1:0]            m_req;
  logic [NUM_MASTERS-1:0]            m_we;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
  logic [NUM_MASTERS*MASK_WIDTH-1:0] m_mask;
  logic [DATA_WIDTH-1:0]             m_rdata;
  logic [NUM_MASTERS-1:0]            m_ready;
  logic [NUM_MASTERS-1:0]            m_err;
  logic                              s_req;
  logic                              s_we;
  logic [ADDR_WIDTH-1:0]             s_addr;
  logic [DATA_WIDTH-1:0]             s_wdata;
  logic [MASK_WIDTH-1:0]             s_mask;
  logic [DATA_WIDTH-1:0]             s_rdata;
  logic                              s_ready;
  modport master (
    input  m_req, m_we, m_addr, m_wdata, m_mask, s_rdata, s_ready,
    output m_rdata, m_ready, m_err, s_req, s_we, s_addr, s_wdata, s_mask
  );
  modport slave (
    output m_req, m_we, m_addr, m_wdata, m_mask, s_rdata, s_ready,
    input  m_rdata, m_ready, m_err, s_req, s_we, s_addr, s_wdata, s_mask
  );
endinterface

// File: rtl/dbus_rr_arbiter.sv
// dbus_rr_arbiter: round-robin N-to-1 registered memory bus arbiter with address mask and timeout
module dbus_rr_arbiter #(
  parameter int                    NUM_MASTERS = 2,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MASK_WIDTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MASK   = 32'h7fff_ffff,
  parameter int                    TIMEOUT     = 255
) (
  input logic              clk,
  input logic              rst,
  dbus_rr_arbiter_if.master bus
);
  localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t          state, nxt;
  logic [IW-1:0]   rr_ptr, g, gnt;
  logic [CW-1:0]   cnt;
  logic            err, tmo;
  // descending scan so the lowest offset from rr_ptr is the last (winning) assignment
  always_comb begin
    gnt = rr_ptr;
    for (int k = NUM_MASTERS - 1; k >= 0; k--)
      if (bus.m_req[(int'(rr_ptr) + k) % NUM_MASTERS]) gnt = IW'((int'(rr_ptr) + k) % NUM_MASTERS);
  end
  always_comb begin
    tmo         = state == BUSY && !bus.s_ready && TIMEOUT != 0 && int'(cnt) == TIMEOUT - 1;
    nxt         = state == IDLE ? (|bus.m_req ? BUSY : IDLE) :
                  state == BUSY ? ((bus.s_ready || tmo) ? DONE : BUSY) : IDLE;
    bus.s_req   = state == BUSY;
    bus.m_ready = state == DONE ? NUM_MASTERS'(1) << g : '0;
    bus.m_err   = state == DONE && err ? NUM_MASTERS'(1) << g : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rr_ptr      <= '0;
      g           <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      bus.s_we    <= 1'b0;
      bus.s_addr  <= '0;
      bus.s_wdata <= '0;
      bus.s_mask  <= '0;
      bus.m_rdata <= '0;
    end else begin
      if (state == IDLE && |bus.m_req) begin
        g           <= gnt;
        bus.s_we    <= bus.m_we[gnt];
        bus.s_addr  <= bus.m_addr[gnt*ADDR_WIDTH +: ADDR_WIDTH] & ADDR_MASK;
        bus.s_wdata <= bus.m_wdata[gnt*DATA_WIDTH +: DATA_WIDTH];
        bus.s_mask  <= bus.m_mask[gnt*MASK_WIDTH +: MASK_WIDTH];
      end
      if (state == BUSY) begin
        cnt <= (bus.s_ready || tmo) ? '0 : cnt + 1'b1;
        err <= tmo;
        if (bus.s_ready) bus.m_rdata <= bus.s_rdata;
        else if (tmo)    bus.m_rdata <= '0;
      end
      if (state == DONE) begin
        rr_ptr <= int'(g) == NUM_MASTERS - 1 ? '0 : g + 1'b1;
        err    <= 1'b0;
      end
    end
endmodule

// File: doc/dbus_rr_arbiter.md
Name: dbus_rr_arbiter

Overview:
- Parametrised N-master to 1-slave memory bus arbiter, successor to the direct ibus/dbus-to-pmem hookup in the SoC top.
- Masters are the core ibus/dbus and future DMA or debug ports; they are granted round-robin.
- Each transaction is registered to the slave with a req/ready handshake.
- Adds an address mask, a per-transaction timeout, and an error flag per master.

Parameters:
- NUM_MASTERS, 2, number of master channels (>=1).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- MASK_WIDTH, 4, byte-enable width (DATA_WIDTH/8).
- ADDR_MASK, 32'h7fff_ffff, ANDed onto the granted address before issue.
- TIMEOUT, 255, maximum cycles waiting for s_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- m_req  in  NUM_MASTERS  per-master request; held until that master's m_ready.
- m_we  in  NUM_MASTERS  per-master write enable.
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  flattened addresses; master i at slice i.
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  flattened write data.
- m_mask  in  NUM_MASTERS*MASK_WIDTH  flattened byte enables.
- m_rdata  out  DATA_WIDTH  read data, shared by all masters; valid only while the owning m_ready bit is 1.
- m_ready  out  NUM_MASTERS  one-cycle completion pulse to the granted master.
- m_err  out  NUM_MASTERS  asserted together with m_ready when the transaction timed out.
- s_req  out  1  slave request.
- s_we  out  1  slave write enable.
- s_addr  out  ADDR_WIDTH  masked address.
- s_wdata  out  DATA_WIDTH  slave write data.
- s_mask  out  MASK_WIDTH  slave byte enables.
- s_rdata  in  DATA_WIDTH  slave read data, sampled when s_ready=1.
- s_ready  in  1  slave completion; may be high in the first s_req cycle (zero-wait slave).

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - rr_ptr=0, timeout counter=0.
  - All outputs are 0; s_req drops immediately, including mid-transaction.
  - No m_ready is produced for an aborted transaction.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any m_req bit is set, grant the first set bit searching from rr_ptr upward, wrapping modulo NUM_MASTERS.
  - Register into s_* : grant index g, m_we[g], m_addr[g]&ADDR_MASK, m_wdata[g], m_mask[g].
  - Next state is BUSY. With no request, remain in IDLE with s_req=0.
- BUSY:
  - s_req=1; all s_* outputs are held stable.
  - On s_ready=1: capture s_rdata into m_rdata (writes capture it too; don't-care for masters), clear the counter, go to DONE.
  - Else the counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with s_ready still 0 in that cycle: set m_rdata=0, set the error flag, go to DONE.
  - s_ready in the same cycle as the timeout threshold counts as success, not timeout.
- DONE:
  - s_req=0; m_ready[g]=1 for exactly one cycle; m_err[g]=error flag.
  - rr_ptr=(g+1) mod NUM_MASTERS; clear the error flag; go to IDLE.
  - m_rdata holds its value until the next capture.
- Latency with a zero-wait slave:
  - Request sampled at edge 0, BUSY during cycle 1, m_ready during cycle 2.
  - Each extra wait cycle on s_ready adds one cycle.
  - Peak throughput is one transaction per 3 cycles.
- Master rules:
  - A master keeps m_req and its payload stable from assertion until it sees m_ready; payload changes before that are ignored after grant.
  - A master still asserting m_req in the cycle after m_ready is treated as a new request.
- Fairness: a continuously requesting master is granted at most once per NUM_MASTERS grants while others are requesting.
- Ungranted masters see m_ready=0 and m_err=0 at all times.
- s_req, s_we, s_addr, s_wdata and s_mask are driven from registers only; there is no combinational path from m_* to s_*.
- NUM_MASTERS=1 degenerates to a registered single-port bridge; rr_ptr stays 0.

Test Plan:
- Reset:
  - Stimulus: assert rst=0 while BUSY with s_req=1.
  - Required: s_req drops with no clock edge; after release, rr_ptr=0 and no m_ready appears.
- Single read, zero-wait slave:
  - Stimulus: m0 reads addr 0x8000_0010; slave returns 0x1234_5678 with s_ready tied 1.
  - Required: s_addr=0x0000_0010 in cycle 1; m_ready=2'b01 and m_rdata=0x1234_5678 in cycle 2.
- Write with wait states:
  - Stimulus: m1 writes 0xCAFE_F00D with mask 4'b0011; s_ready rises after 3 cycles.
  - Required: s_we=1 and s_mask=4'b0011 held stable for 4 cycles; m_ready=2'b10 exactly one cycle; m_err=0.
- Round-robin contention:
  - Stimulus: m0 and m1 request continuously from reset.
  - Required: grant order m0, m1, m0, m1; m_ready pulses alternate every 3 cycles.
- Timeout:
  - Stimulus: TIMEOUT=4, s_ready never asserted.
  - Required: s_req high for exactly 4 cycles; then m_ready[g]=1, m_err[g]=1, m_rdata=0; FSM returns to IDLE.
- Timeout-edge success:
  - Stimulus: TIMEOUT=4, s_ready asserted on the 4th BUSY cycle.
  - Required: m_err=0 and m_rdata equals s_rdata.
